bcd_countdown: RTL

- Multi-digit, loadable BCD down-counter (countdown timer) with start/stop control and an expiry pulse.
- Counterpart to the up-counting BCD counter: decrements with digit-to-digit borrow instead of incrementing with ripple carry.
- Driven by a single-cycle tick from a prescaler; feeds the seven-segment digit decoders and game/timer control logic.

---
 rtl/bcd_countdown.sv | 110 +++++++++++
 1 files changed

// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD countdown timer with start/stop control and a one-cycle expiry pulse.
// Optional BCD_COUNTDOWN_AUTO_RELOAD_EN: on expiry, reload from the last loaded value and keep running.
module bcd_countdown #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  clear_,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  zero,
    output logic                  done
);
    localparam int W = 4*DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic           running_q;
    logic           done_q;
    logic [W-1:0]   data_sat;
    logic [W-1:0]   count_dec;
    logic [W-1:0]   reload_val;
    logic           borrow;
    logic           at_one;
    logic           nonzero;

    // Out-of-range preset digits clamp to 9 so the counter never holds a non-BCD digit.
    always_comb begin
        data_sat = data;
        for (int i = 0; i < DIGITS; i++)
            if (data[4*i +: 4] > 4'd9) data_sat[4*i +: 4] = 4'd9;
    end

    always_comb begin
        borrow    = 1'b1;
        count_dec = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign at_one  = (count_q == W'(1));
    assign nonzero = |count_q;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0] reload_q;

    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_)   reload_q <= '0;
        else if (load) reload_q <= data_sat;
    end

    assign reload_val = reload_q;
`else
    assign reload_val = '0;
`endif

    // Priority load > stop > start > tick; an input that does not apply in the current state does not block lower ones.
    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            state_q   <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                count_q   <= data_sat;
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else if (stop && state_q == RUN) begin
                state_q   <= PAUSED;
                running_q <= 1'b0;
            end else if (start && (state_q == IDLE || state_q == PAUSED) && nonzero) begin
                state_q   <= RUN;
                running_q <= 1'b1;
            end else if (tick && state_q == RUN) begin
                done_q <= at_one;
                if (!at_one) begin
                    count_q <= count_dec;
                end else if (reload_val != '0) begin
                    count_q <= reload_val;
                end else begin
                    count_q   <= '0;
                    state_q   <= EXPIRED;
                    running_q <= 1'b0;
                end
            end
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign zero    = ~nonzero;

endmodule
